// File: rtl/extrema_scheduler_if.sv
// Control, checker and keypoint-stream signals of the extrema scheduler.
// EXTREMA_SCHED_COUNT_EN adds the kp_count accepted-record counter.
interface extrema_scheduler_if #(
  parameter int unsigned DIMENSION   = 4,
  parameter int unsigned NUM_OCTAVES = 3
);
  localparam int unsigned XW = $clog2(DIMENSION);
  localparam int unsigned OW = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1;
  localparam int unsigned KW = OW + 1 + 2 * XW;

  logic          start;
  logic          busy;
  logic          done;
  logic [OW-1:0] octave_sel;
  logic          chk_enable;
  logic [XW-1:0] chk_x;
  logic [XW-1:0] chk_y;
  logic          chk_first_ext;
  logic          chk_second_ext;
  logic          chk_done;
  logic          kp_valid;
  logic          kp_ready;
  logic [KW-1:0] kp_data;
  logic [7:0]    drop_count;
`ifdef EXTREMA_SCHED_COUNT_EN
  logic [15:0]   kp_count;

  modport slave (
    input  start, chk_x, chk_y, chk_first_ext, chk_second_ext, chk_done, kp_ready,
    output busy, done, octave_sel, chk_enable, kp_valid, kp_data, drop_count, kp_count
  );
  modport master (
    output start, chk_x, chk_y, chk_first_ext, chk_second_ext, chk_done, kp_ready,
    input  busy, done, octave_sel, chk_enable, kp_valid, kp_data, drop_count, kp_count
  );
`else
  modport slave (
    input  start, chk_x, chk_y, chk_first_ext, chk_second_ext, chk_done, kp_ready,
    output busy, done, octave_sel, chk_enable, kp_valid, kp_data, drop_count
  );
  modport master (
    output start, chk_x, chk_y, chk_first_ext, chk_second_ext, chk_done, kp_ready,
    input  busy, done, octave_sel, chk_enable, kp_valid, kp_data, drop_count
  );
`endif
endinterface

// File: rtl/extrema_scheduler.sv
// Runs one extrema-check pass per octave and buffers keypoint records in a FIFO.
// Optional feature macro: EXTREMA_SCHED_COUNT_EN (kp_count output).
module extrema_scheduler #(
  parameter int unsigned DIMENSION   = 4,
  parameter int unsigned NUM_OCTAVES = 3,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input logic                clk,
  input logic                rst_in,
  extrema_scheduler_if.slave bus_io
);
  localparam int unsigned XW = $clog2(DIMENSION);
  localparam int unsigned OW = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1;
  localparam int unsigned KW = OW + 1 + 2 * XW;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [OW-1:0] LastOct = OW'(NUM_OCTAVES - 1);
  localparam logic [AW:0]   FullCnt = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StNext, StDrain, StFin} state_e;

  state_e        state_q;
  logic          busy_q, done_q, chk_enable_q;
  logic [OW-1:0] octave_q;

  logic          skid_valid_q, skid_valid_d;
  logic [KW-1:0] skid_data_q, skid_data_d;
  logic [KW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    drop_count_q, drop_count_d;

  logic          run_start, capture, fifo_full, pop, push_req, push;
  logic [KW-1:0] rec0, rec1, push_data;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;

  assign run_start = (state_q == StIdle) && bus_io.start;
  assign capture   = (state_q == StWait);
  assign rec0      = {octave_q, 1'b0, bus_io.chk_x, bus_io.chk_y};
  assign rec1      = {octave_q, 1'b1, bus_io.chk_x, bus_io.chk_y};
  assign fifo_full = (count_q == FullCnt);
  assign pop       = (count_q != '0) && bus_io.kp_ready;

  // One FIFO write per cycle: a pending skid record wins over fresh strobes.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    push_req     = 1'b0;
    push_data    = rec0;
    drop_inc     = 2'd0;
    if (skid_valid_q) begin
      push_req     = 1'b1;
      push_data    = skid_data_q;
      skid_valid_d = 1'b0;
      if (capture) begin
        drop_inc = {1'b0, bus_io.chk_first_ext} + {1'b0, bus_io.chk_second_ext};
      end
    end else if (capture) begin
      if (bus_io.chk_first_ext) begin
        push_req = 1'b1;
        if (bus_io.chk_second_ext) begin
          skid_valid_d = 1'b1;
          skid_data_d  = rec1;
        end
      end else if (bus_io.chk_second_ext) begin
        push_req  = 1'b1;
        push_data = rec1;
      end
    end
    push = push_req && (!fifo_full || pop);
    if (push_req && !push) begin
      drop_inc = drop_inc + 2'd1;
    end
    drop_sum     = {1'b0, drop_count_q} + {7'd0, drop_inc};
    drop_count_d = run_start ? 8'd0 : (drop_sum[8] ? 8'hFF : drop_sum[7:0]);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      chk_enable_q <= 1'b0;
      octave_q     <= '0;
    end else begin
      done_q       <= 1'b0;
      chk_enable_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q      <= StLaunch;
            busy_q       <= 1'b1;
            chk_enable_q <= 1'b1;
            octave_q     <= '0;
          end
        end
        StLaunch: state_q <= StWait;
        StWait: begin
          if (bus_io.chk_done) state_q <= StNext;
        end
        StNext: begin
          if (octave_q == LastOct) begin
            state_q <= StDrain;
          end else begin
            octave_q     <= octave_q + 1'b1;
            chk_enable_q <= 1'b1;
            state_q      <= StLaunch;
          end
        end
        StDrain: begin
          if ((count_q == '0) && !skid_valid_q) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      skid_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      drop_count_q <= drop_count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

`ifdef EXTREMA_SCHED_COUNT_EN
  logic [15:0] kp_count_q;

  always_ff @(posedge clk) begin
    if (rst_in || run_start) begin
      kp_count_q <= '0;
    end else if (push && (kp_count_q != 16'hFFFF)) begin
      kp_count_q <= kp_count_q + 16'd1;
    end
  end

  assign bus_io.kp_count = kp_count_q;
`endif

  assign bus_io.busy       = busy_q;
  assign bus_io.done       = done_q;
  assign bus_io.chk_enable = chk_enable_q;
  assign bus_io.octave_sel = octave_q;
  assign bus_io.kp_valid   = (count_q != '0);
  assign bus_io.kp_data    = mem_q[rd_ptr_q];
  assign bus_io.drop_count = drop_count_q;
endmodule

// File: tb/tb_extrema_scheduler.sv
// Self-checking bench for extrema_scheduler: directed scenarios plus randomized runs
// compared against a queue-based keypoint model.
module tb_extrema_scheduler;
  localparam int unsigned DIM   = 4;
  localparam int unsigned NOCT  = 3;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_in;
  int   errors = 0;
  int   checks = 0;

  extrema_scheduler_if #(.DIMENSION(DIM), .NUM_OCTAVES(NOCT)) bus ();

  extrema_scheduler #(.DIMENSION(DIM), .NUM_OCTAVES(NOCT), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Reference model: queue of records in FIFO order, one skid slot, drop/accept tallies.
  logic [6:0] mq[$];
  bit         m_skid_v;
  logic [6:0] m_skid;
  int         m_drops;
  int         m_acc;
  logic [1:0] moct;

  task automatic model_step(input bit in_wait, input bit f, input bit s,
                            input logic [1:0] x, input logic [1:0] y, input bit rdy);
    bit pop, acc, have;
    logic [6:0] cand;
    int nd;
    pop  = (mq.size() != 0) && rdy;
    acc  = (mq.size() < DEPTH) || pop;
    have = 0;
    cand = '0;
    nd   = 0;
    if (m_skid_v) begin
      have = 1; cand = m_skid; m_skid_v = 0;
      if (in_wait) nd = int'(f) + int'(s);
    end else if (in_wait) begin
      if (f) begin
        have = 1; cand = {moct, 1'b0, x, y};
        if (s) begin m_skid_v = 1; m_skid = {moct, 1'b1, x, y}; end
      end else if (s) begin
        have = 1; cand = {moct, 1'b1, x, y};
      end
    end
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (acc) begin mq.push_back(cand); m_acc++; end
      else nd++;
    end
    m_drops += nd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.chk_x = '0; bus.chk_y = '0; bus.chk_first_ext = 0;
    bus.chk_second_ext = 0; bus.chk_done = 0; bus.kp_ready = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask

  // Returns at a negedge with the DUT in its wait-for-checker state.
  task automatic enter_wait(output bit ok, output logic [1:0] oct);
    ok = 0; oct = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.chk_enable) begin ok = 1; oct = bus.octave_sel; end
      else tick();
    end
    if (ok) tick();
  endtask

  task automatic end_pass();
    bus.chk_done = 1;
    tick();
    bus.chk_done = 0;
  endtask

  task automatic finish_passes(input int cur, output bit ok);
    bit e;
    logic [1:0] oc;
    ok = 1;
    end_pass();
    for (int o = cur + 1; o < NOCT; o++) begin
      enter_wait(e, oc);
      if (!e) ok = 0;
      end_pass();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.done) ok = 1;
      else tick();
    end
    if (ok) tick();
  endtask

  task automatic test_reset();
    logic [1:0] en_q[$];
    bit seen_done, saw_valid;
    rst_in = 1; idle_inputs(); tick(); tick(); rst_in = 0;
    checks++;
    if ({bus.busy, bus.done, bus.chk_enable, bus.octave_sel, bus.kp_valid, bus.drop_count}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b en=%0b oct=%0d valid=%0b drops=%0d",
               bus.busy, bus.done, bus.chk_enable, bus.octave_sel, bus.kp_valid,
               bus.drop_count);
    end
    bus.chk_done = 1;
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %0b want 1", bus.busy); end
    seen_done = 0; saw_valid = 0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (bus.done) seen_done = 1;
      else begin
        if (bus.chk_enable) en_q.push_back(bus.octave_sel);
        if (bus.kp_valid) saw_valid = 1;
        tick();
      end
    end
    checks++;
    if (!seen_done) begin errors++; $display("FAIL tied_done_run: got no done want done"); end
    checks++;
    if (en_q.size() != 3 || en_q[0] !== 2'd0 || en_q[1] !== 2'd1 || en_q[2] !== 2'd2) begin
      errors++;
      $display("FAIL launch_sequence: got %0d launches want octaves 0,1,2", en_q.size());
    end
    checks++;
    if (saw_valid) begin errors++; $display("FAIL tied_done_records: got kp_valid want none"); end
    tick();
    bus.chk_done = 0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %0b want 0", bus.busy); end
  endtask

  task automatic test_single_strobe();
    bit ok, ok2;
    logic [1:0] oc;
    idle_inputs();
    pulse_start();
    enter_wait(ok, oc);
    end_pass();
    enter_wait(ok, oc);
    checks++;
    if (!ok || oc !== 2'd1) begin errors++; $display("FAIL single_octave: got %0d want 1", oc); end
    bus.chk_first_ext = 1; bus.chk_x = 2'd2; bus.chk_y = 2'd1;
    tick();
    bus.chk_first_ext = 0;
    checks++;
    if ({bus.kp_valid, bus.kp_data} !== {1'b1, 2'd1, 1'b0, 2'd2, 2'd1}) begin
      errors++;
      $display("FAIL single_record: got valid=%0b data=%0h want valid=1 data=%0h",
               bus.kp_valid, bus.kp_data, 7'b0101001);
    end
    finish_passes(1, ok);
    bus.kp_ready = 1;
    wait_done(ok2);
    checks++;
    if (!(ok && ok2) || bus.drop_count !== 8'd0) begin
      errors++;
      $display("FAIL single_done: got done=%0b drops=%0d want done with 0 drops",
               ok && ok2, bus.drop_count);
    end
    bus.kp_ready = 0;
  endtask

  task automatic test_dual_strobe();
    bit ok, ok2;
    logic [1:0] oc;
    idle_inputs();
    bus.kp_ready = 1;
    pulse_start();
    enter_wait(ok, oc);
    bus.chk_first_ext = 1; bus.chk_second_ext = 1; bus.chk_x = 2'd1; bus.chk_y = 2'd2;
    tick();
    bus.chk_first_ext = 0; bus.chk_second_ext = 0;
    checks++;
    if ({bus.kp_valid, bus.kp_data} !== {1'b1, 7'b0000110}) begin
      errors++; $display("FAIL dual_layer0: got %0b/%0h want 1/%0h", bus.kp_valid, bus.kp_data, 7'b0000110);
    end
    tick();
    checks++;
    if ({bus.kp_valid, bus.kp_data} !== {1'b1, 7'b0010110}) begin
      errors++; $display("FAIL dual_layer1: got %0b/%0h want 1/%0h", bus.kp_valid, bus.kp_data, 7'b0010110);
    end
    tick();
    checks++;
    if (bus.kp_valid !== 1'b0) begin errors++; $display("FAIL dual_empty: got %0b want 0", bus.kp_valid); end
    finish_passes(0, ok);
    wait_done(ok2);
    checks++;
    if (!(ok && ok2)) begin errors++; $display("FAIL dual_done: got no done want done"); end
    bus.kp_ready = 0;
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    logic [1:0] oc;
    logic [6:0] exp;
    idle_inputs();
    pulse_start();
    enter_wait(ok, oc);
    for (int i = 0; i < 10; i++) begin
      bus.chk_first_ext = 1; bus.chk_x = 2'(i); bus.chk_y = 2'(i >> 2);
      tick();
    end
    bus.chk_first_ext = 0;
    checks++;
    if ({bus.kp_valid, bus.drop_count} !== {1'b1, 8'd2}) begin
      errors++; $display("FAIL bp_drops: got valid=%0b drops=%0d want 1/2", bus.kp_valid, bus.drop_count);
    end
    finish_passes(0, ok);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      errors++; $display("FAIL bp_hold: got busy=%0b done=%0b want 1/0", bus.busy, bus.done);
    end
    bus.kp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      exp = {2'd0, 1'b0, 2'(i), 2'(i >> 2)};
      checks++;
      if ({bus.done, bus.kp_valid, bus.kp_data} !== {1'b0, 1'b1, exp}) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got done=%0b valid=%0b data=%0h want 0/1/%0h",
                 i, bus.done, bus.kp_valid, bus.kp_data, exp);
      end
      tick();
    end
    checks++;
    if ({bus.done, bus.kp_valid} !== 2'b00) begin
      errors++; $display("FAIL bp_last_pop: got done=%0b valid=%0b want 0/0", bus.done, bus.kp_valid);
    end
    wait_done(ok2);
    checks++;
    if (!(ok && ok2) || bus.drop_count !== 8'd2) begin
      errors++; $display("FAIL bp_done: got done=%0b drops=%0d want 1/2", ok && ok2, bus.drop_count);
    end
    bus.kp_ready = 0;
  endtask

  task automatic test_full_pop();
    bit ok, ok2;
    logic [1:0] oc;
    logic [6:0] exp[8];
    idle_inputs();
    pulse_start();
    enter_wait(ok, oc);
    for (int i = 0; i < 8; i++) begin
      bus.chk_first_ext = 1; bus.chk_x = 2'(i); bus.chk_y = 2'(i >> 2);
      tick();
      if (i < 7) exp[i] = {2'd0, 1'b0, 2'(i + 1), 2'((i + 1) >> 2)};
    end
    exp[7] = {2'd0, 1'b0, 2'd3, 2'd3};
    bus.kp_ready = 1; bus.chk_x = 2'd3; bus.chk_y = 2'd3;
    tick();
    bus.chk_first_ext = 0; bus.kp_ready = 0;
    checks++;
    if ({bus.drop_count, bus.kp_data} !== {8'd0, exp[0]}) begin
      errors++; $display("FAIL full_pop_accept: got drops=%0d head=%0h want 0/%0h",
                         bus.drop_count, bus.kp_data, exp[0]);
    end
    finish_passes(0, ok);
    bus.kp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.kp_valid, bus.kp_data} !== {1'b1, exp[i]}) begin
        errors++; $display("FAIL full_pop_order[%0d]: got %0b/%0h want 1/%0h",
                           i, bus.kp_valid, bus.kp_data, exp[i]);
      end
      tick();
    end
    wait_done(ok2);
    checks++;
    if (!(ok && ok2)) begin errors++; $display("FAIL full_pop_done: got no done want done"); end
    bus.kp_ready = 0;
  endtask

  task automatic test_saturation();
    bit ok, ok2;
    logic [1:0] oc;
    idle_inputs();
    pulse_start();
    enter_wait(ok, oc);
    bus.chk_first_ext = 1;
    for (int i = 0; i < 270; i++) tick();
    bus.chk_first_ext = 0;
    checks++;
    if (bus.drop_count !== 8'hFF) begin
      errors++; $display("FAIL drop_saturate: got %0d want 255", bus.drop_count);
    end
    bus.kp_ready = 1;
    finish_passes(0, ok);
    wait_done(ok2);
    checks++;
    if (!(ok && ok2)) begin errors++; $display("FAIL saturate_done: got no done want done"); end
    bus.kp_ready = 0;
  endtask

  task automatic test_abort();
    bit ok, saw_done;
    logic [1:0] oc;
    idle_inputs();
    pulse_start();
    enter_wait(ok, oc);
    for (int i = 0; i < 3; i++) begin
      bus.chk_first_ext = 1; bus.chk_x = 2'(i);
      tick();
    end
    bus.chk_first_ext = 0;
    rst_in = 1;
    tick();
    checks++;
    if ({bus.busy, bus.kp_valid, bus.done} !== 3'b000) begin
      errors++; $display("FAIL abort_state: got busy=%0b valid=%0b done=%0b want 0/0/0",
                         bus.busy, bus.kp_valid, bus.done);
    end
    rst_in = 0;
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) saw_done = 1;
      tick();
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_no_done: got done pulse want none"); end
  endtask

  task automatic test_random();
    bit finished, pend, f, s, rdy;
    int wait_left, passes, expd;
    logic [1:0] x, y;
    logic [6:0] hd;
    for (int run = 0; run < 4; run++) begin
      idle_inputs();
      mq.delete(); m_skid_v = 0; m_drops = 0; m_acc = 0; moct = '0;
      pulse_start();
      finished = 0; wait_left = 0; passes = 0;
      for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
        hd   = (mq.size() != 0) ? mq[0] : 7'd0;
        expd = (m_drops > 255) ? 255 : m_drops;
        checks++;
        if ({bus.kp_valid, bus.kp_valid ? bus.kp_data : 7'd0, bus.drop_count} !==
            {mq.size() != 0, hd, 8'(expd)}) begin
          errors++;
          $display("FAIL rand_stream run%0d cyc%0d: got valid=%0b data=%0h drops=%0d want %0b/%0h/%0d",
                   run, cyc, bus.kp_valid, bus.kp_data, bus.drop_count, mq.size() != 0, hd, expd);
        end
        if (bus.done) begin
          finished = 1;
        end else begin
          pend = bus.chk_enable;
          if (pend) begin
            checks++;
            if (bus.octave_sel !== 2'(passes)) begin
              errors++; $display("FAIL rand_octave: got %0d want %0d", bus.octave_sel, passes);
            end
          end
          rdy = ($urandom_range(0, 1) == 1);
          f   = ($urandom_range(0, 2) == 0);
          s   = ($urandom_range(0, 2) == 0);
          x   = 2'($urandom_range(0, 3));
          y   = 2'($urandom_range(0, 3));
          bus.kp_ready = rdy; bus.chk_first_ext = f; bus.chk_second_ext = s;
          bus.chk_x = x; bus.chk_y = y; bus.chk_done = (wait_left == 1);
          model_step(wait_left > 0, f, s, x, y, rdy);
          tick();
          if (wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) begin passes++; moct++; end
          end
          if (pend) wait_left = $urandom_range(1, 10);
        end
      end
      checks++;
      if (!finished || passes != NOCT || mq.size() != 0 || m_skid_v) begin
        errors++;
        $display("FAIL rand_run%0d_end: got done=%0b passes=%0d pending=%0d want done/%0d/0",
                 run, finished, passes, mq.size(), NOCT);
      end
`ifdef EXTREMA_SCHED_COUNT_EN
      checks++;
      if (bus.kp_count !== 16'(m_acc)) begin
        errors++; $display("FAIL rand_kp_count: got %0d want %0d", bus.kp_count, m_acc);
      end
`endif
      idle_inputs();
      tick();
    end
  endtask

  initial begin
    rst_in = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_strobe();
    test_dual_strobe();
    test_backpressure();
    test_full_pop();
    test_saturation();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
